// File: rtl/spi_trace_rx_pkg.sv
// Shared types and constants for the SPI debug trace receiver.
// Imported by the framing top and its output FIFO.
package spi_trace_rx_pkg;

    localparam int SPI_WORD_W = 32;
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [2:0] {
        RESYNC,
        IDLE,
        SHIFT,
        FULL,
        BAD
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a flop-backed head and a drop pulse.
// A push into a full FIFO is discarded unless a pop happens in the same cycle.
module sync_fifo
    import spi_trace_rx_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign level   = wr_ptr - rd_ptr;
    assign valid   = (level != '0);
    assign full    = (level == LVL_FULL);
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_trace_rx.sv
// Oversampling SPI mode-0 frame receiver for one debug channel.
// Reassembles cs-framed words and queues them behind a valid/ready port.
module spi_trace_rx
    import spi_trace_rx_pkg::*;
#(
    parameter int WIDTH       = SPI_WORD_W,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_sck,
    input  logic                    spi_cs,
    input  logic                    spi_mosi,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    frame_err,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic                    overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise;
    logic                   cs_fall;
    logic                   cs_rise;

    rx_state_t              state;
    rx_state_t              state_d;
    logic [WIDTH-1:0]       shreg;
    logic [CW-1:0]          bitcnt;
    logic                   shift_en;
    logic                   clr_cnt;
    logic                   push_req;
    logic                   err_req;

    logic                   fifo_full;
    logic                   fifo_drop;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;

    // Synchronizers plus one edge-detect stage; cs resets low so RESYNC
    // waits for a genuine idle level before accepting a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    // Framing state register.
    always_ff @(posedge clk) begin
        if (rst) state <= RESYNC;
        else     state <= state_d;
    end

    // Framing decisions; cs_rise always wins over a coincident sck_rise.
    always_comb begin
        state_d  = state;
        shift_en = 1'b0;
        clr_cnt  = 1'b0;
        push_req = 1'b0;
        err_req  = 1'b0;
        unique case (state)
            RESYNC: begin
                if (cs_s) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    clr_cnt = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    err_req = 1'b1;
                    state_d = IDLE;
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                    if (bitcnt == CW'(WIDTH - 1)) state_d = FULL;
                end
            end
            FULL: begin
                if (cs_rise) begin
                    push_req = 1'b1;
                    state_d  = IDLE;
                end else if (sck_rise) begin
                    state_d = BAD;
                end
            end
            BAD: begin
                if (cs_rise) begin
                    err_req = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = RESYNC;
        endcase
    end

    // Shift register, bit counter and error/overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bitcnt    <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= err_req;
            if (err_req && (err_count != '1)) err_count <= err_count + 1'b1;
            if (clr_cnt) begin
                bitcnt <= '0;
            end else if (shift_en) begin
                shreg  <= {shreg[WIDTH-2:0], mosi_s};
                bitcnt <= bitcnt + 1'b1;
            end
            if (fifo_drop & fifo_full) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (shreg),
        .pop       (out_ready),
        .head      (out_data),
        .valid     (out_valid),
        .level     (level),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

endmodule

// File: tb/tb_spi_trace_rx.sv
// Scoreboard bench for spi_trace_rx: bit-banged SPI frames in,
// expected words queued by a frame-level model, checked by a monitor.
module tb_spi_trace_rx;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_sck;
    logic          spi_cs;
    logic          spi_mosi;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          frame_err;
    logic [7:0]    err_count;
    logic          overflow;

    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  exp_q[$];
    int            model_level;
    int            exp_err;
    logic          exp_ovf;
    int            err_pulses;
    int            valid_cycles;
    logic          rand_ready = 1'b0;

    always #5 clk = ~clk;

    spi_trace_rx #(
        .WIDTH       (W),
        .DEPTH       (D),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_sck   (spi_sck),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .frame_err (frame_err),
        .err_count (err_count),
        .overflow  (overflow)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every accepted output word.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_pulses++;
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL word: got %08h expected none", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    model_level--;
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL word: got %08h expected %08h", out_data, e);
                    end
                end
            end
        end
    end

    // Randomised consumer backpressure.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_model();
        exp_q.delete();
        model_level  = 0;
        exp_err      = 0;
        exp_ovf      = 1'b0;
        err_pulses   = 0;
        valid_cycles = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        spi_cs    = 1'b1;
        spi_sck   = 1'b0;
        spi_mosi  = 1'b0;
        out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        clear_model();
        tick(6);
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        tick(4);
        spi_sck = 1'b1;
        tick(4);
        spi_sck = 1'b0;
    endtask

    // Frame model: only exact-length frames deliver a word; a full FIFO
    // drops it unless a pop lands in the very cycle of the push.
    task automatic send_frame(input logic [W-1:0] w, input int nbits, input bit pop_same);
        spi_cs = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) send_bit((i < W) ? w[W-1-i] : 1'b0);
        tick(4);
        spi_cs = 1'b1;
        if (nbits == W) begin
            if (model_level < D || pop_same) begin
                exp_q.push_back(w);
                model_level++;
            end else begin
                exp_ovf = 1'b1;
            end
        end else begin
            exp_err++;
        end
        if (pop_same) begin
            tick(2);
            out_ready = 1'b1;
            tick(1);
            out_ready = 1'b0;
        end
        tick(8);
    endtask

    task automatic drain(input string name);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick(1);
            n++;
        end
        tick(5);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        int           n;

        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_overflow", overflow, 0);

        // single good word
        do_reset();
        out_ready = 1'b1;
        send_frame(32'hDEADBEEF, W, 0);
        drain("t1");
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_err_pulses", err_pulses, 0);
        check("t1_err_count", err_count, 0);

        // short frame then good frame
        do_reset();
        out_ready = 1'b1;
        send_frame($urandom, 20, 0);
        send_frame(32'h12345678, W, 0);
        drain("t2");
        check("t2_err_pulses", err_pulses, 1);
        check("t2_err_count", err_count, 1);
        check("t2_valid_cycles", valid_cycles, 1);

        // long frame
        do_reset();
        out_ready = 1'b1;
        send_frame($urandom, 33, 0);
        tick(10);
        check("t3_err_pulses", err_pulses, 1);
        check("t3_err_count", err_count, 1);
        check("t3_valid_cycles", valid_cycles, 0);

        // overflow with stalled consumer
        do_reset();
        for (int i = 1; i <= 10; i++) send_frame(W'(i), W, 0);
        tick(10);
        check("t4_level_full", level, D);
        check("t4_overflow", overflow, exp_ovf);
        drain("t4");
        check("t4_level_empty", level, 0);

        // push into a full FIFO with a coincident pop
        do_reset();
        for (int i = 0; i < D; i++) send_frame($urandom, W, 0);
        check("t5_level_full", level, D);
        w = $urandom;
        send_frame(w, W, 1);
        tick(4);
        check("t5_level_after", level, D);
        check("t5_overflow", overflow, exp_ovf);
        check("t5_last_is_new", exp_q[exp_q.size()-1], w);
        drain("t5");

        // reset in the middle of a frame
        do_reset();
        out_ready = 1'b1;
        w = $urandom;
        spi_cs = 1'b0;
        tick(4);
        for (int i = 0; i < 12; i++) send_bit(w[W-1-i]);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        clear_model();
        out_ready = 1'b1;
        for (int i = 12; i < W; i++) send_bit(w[W-1-i]);
        tick(4);
        spi_cs = 1'b1;
        tick(8);
        send_frame(32'hCAFEF00D, W, 0);
        drain("t6");
        check("t6_err_count", err_count, 0);
        check("t6_err_pulses", err_pulses, 0);
        check("t6_valid_cycles", valid_cycles, 1);

        // random mix of lengths and backpressure
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, W - 1);
                1:       n = $urandom_range(W + 1, W + 4);
                default: n = W;
            endcase
            send_frame($urandom, n, 0);
        end
        rand_ready = 1'b0;
        tick(2);
        drain("t7");
        check("t7_err_count", err_count, exp_err);
        check("t7_err_pulses", err_pulses, exp_err);
        check("t7_overflow", overflow, exp_ovf);
        check("t7_level", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
